// File: rtl/tlk2711_axil_reg_bridge.sv
// AXI4-Lite slave that serialises PS accesses onto the TLK2711 simple register bus.
// Define REG_BRIDGE_ADDR_CHECK_EN to answer misaligned or out-of-range addresses with SLVERR.
module tlk2711_axil_reg_bridge #(
    parameter int          RD_LATENCY = 6,
    parameter logic [15:0] MAX_ADDR   = 16'h0100
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] s_axil_awaddr,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [63:0] s_axil_wdata,
    input  logic [7:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,

    input  logic [31:0] s_axil_araddr,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [63:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,

    output logic        o_reg_wen,
    output logic [15:0] o_reg_waddr,
    output logic [63:0] o_reg_wdata,
    output logic        o_reg_ren,
    output logic [15:0] o_reg_raddr,
    input  logic [63:0] i_reg_rdata
);

    typedef enum logic [2:0] {IDLE, WR_STB, WR_RESP, RD_STB, RD_WAIT, RD_RESP} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] CNT_INIT    = 4'(RD_LATENCY - 1);

    state_e      state_q, state_d;
    logic        wr_prio_q, wr_prio_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] raddr_q, raddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;

    logic wr_req, rd_req, grant_wr, grant_rd;
    logic wr_addr_err, rd_addr_err;

    // A write needs AW and W together; on a tie the type not granted last time wins.
    assign wr_req   = s_axil_awvalid && s_axil_wvalid;
    assign rd_req   = s_axil_arvalid;
    assign grant_wr = (state_q == IDLE) && wr_req && (!rd_req || wr_prio_q);
    assign grant_rd = (state_q == IDLE) && rd_req && !grant_wr;

`ifdef REG_BRIDGE_ADDR_CHECK_EN
    assign wr_addr_err = (s_axil_awaddr[2:0] != 3'b000) || (s_axil_awaddr[15:0] > MAX_ADDR);
    assign rd_addr_err = (s_axil_araddr[2:0] != 3'b000) || (s_axil_araddr[15:0] > MAX_ADDR);
`else
    assign wr_addr_err = 1'b0;
    assign rd_addr_err = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axil_awaddr[31:16], s_axil_araddr[31:16], s_axil_wstrb, MAX_ADDR};

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d   = state_q;
        wr_prio_d = wr_prio_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;

        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d   = WR_STB;
                    waddr_d   = s_axil_awaddr[15:0];
                    wdata_d   = s_axil_wdata;
                    err_d     = wr_addr_err;
                    wr_prio_d = 1'b0;
                end else if (grant_rd) begin
                    state_d   = RD_STB;
                    raddr_d   = s_axil_araddr[15:0];
                    err_d     = rd_addr_err;
                    wr_prio_d = 1'b1;
                end
            end
            WR_STB: begin
                bresp_d = err_q ? RESP_SLVERR : RESP_OKAY;
                state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_axil_bready) state_d = IDLE;
            end
            RD_STB: begin
                cnt_d = CNT_INIT;
                if (err_q) begin
                    // Rejected reads skip the latency wait and answer with zero data.
                    rdata_d = '0;
                    rresp_d = RESP_SLVERR;
                    state_d = RD_RESP;
                end else begin
                    rresp_d = RESP_OKAY;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = i_reg_rdata;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (s_axil_rready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the data/address registers are reset too, since they drive bus outputs that must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_prio_q <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            rdata_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
            state_q   <= state_d;
            wr_prio_q <= wr_prio_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axil_awready = grant_wr;
    assign s_axil_wready  = grant_wr;
    assign s_axil_arready = grant_rd;
    assign s_axil_bvalid  = (state_q == WR_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = (state_q == RD_RESP);
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

    assign o_reg_wen   = (state_q == WR_STB) && !err_q;
    assign o_reg_ren   = (state_q == RD_STB) && !err_q;
    assign o_reg_waddr = waddr_q;
    assign o_reg_wdata = wdata_q;
    assign o_reg_raddr = raddr_q;

endmodule

// File: tb/tb_tlk2711_axil_reg_bridge.sv
// Randomised bench for tlk2711_axil_reg_bridge: a memory-like register block model plus
// a cycle-exact transaction checker; honours REG_BRIDGE_ADDR_CHECK_EN when defined.
module tb_tlk2711_axil_reg_bridge;

    localparam int          RD_LATENCY = 6;
    localparam logic [15:0] MAX_ADDR   = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axil_awaddr = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [63:0] s_axil_wdata = '0;
    logic [7:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b0;
    logic [31:0] s_axil_araddr = '0;
    logic        s_axil_arvalid = 1'b0;
    logic        s_axil_arready;
    logic [63:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready = 1'b0;
    logic        o_reg_wen;
    logic [15:0] o_reg_waddr;
    logic [63:0] o_reg_wdata;
    logic        o_reg_ren;
    logic [15:0] o_reg_raddr;
    logic [63:0] i_reg_rdata = '0;

    tlk2711_axil_reg_bridge #(.RD_LATENCY(RD_LATENCY), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr), .o_reg_wdata(o_reg_wdata),
        .o_reg_ren(o_reg_ren), .o_reg_raddr(o_reg_raddr), .i_reg_rdata(i_reg_rdata)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit prio_wr = 1'b1;

    logic [63:0] exp_mem [logic [15:0]];  // what the PS believes it has written
    logic [63:0] blk_mem [logic [15:0]];  // what the register block actually received
    int          due_q[$];
    logic [15:0] rda_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] dflt(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, 16'hC3C3};
    endfunction

    function automatic logic [63:0] exp_rd(input logic [15:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
    endfunction

    function automatic logic [63:0] blk_rd(input logic [15:0] a);
        return blk_mem.exists(a) ? blk_mem[a] : dflt(a);
    endfunction

    function automatic bit addr_err(input logic [15:0] a);
`ifdef REG_BRIDGE_ADDR_CHECK_EN
        return (a % 8 != 0) || (a > MAX_ADDR);
`else
        return (a != a);
`endif
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 16'h0120));
        return 16'($urandom_range(0, 12) * 8);
    endfunction

    // Register block: stores strobed writes, returns read data exactly RD_LATENCY cycles after the
    // read strobe and garbage in every other cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            rda_q.delete();
        end else begin
            if (o_reg_wen) blk_mem[o_reg_waddr] = o_reg_wdata;
            if (o_reg_ren) begin
                due_q.push_back(cyc + RD_LATENCY);
                rda_q.push_back(o_reg_raddr);
            end
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            i_reg_rdata = blk_rd(rda_q[0]);
            void'(due_q.pop_front());
            void'(rda_q.pop_front());
        end else begin
            i_reg_rdata = {$urandom, $urandom};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_busy(input string tag, input bit exp_wen, input bit exp_ren);
        check({tag, ".wen"}, o_reg_wen, exp_wen);
        check({tag, ".ren"}, o_reg_ren, exp_ren);
        check({tag, ".awready"}, s_axil_awready, 0);
        check({tag, ".wready"}, s_axil_wready, 0);
        check({tag, ".arready"}, s_axil_arready, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".awready"}, s_axil_awready, 0);
        check({tag, ".wready"}, s_axil_wready, 0);
        check({tag, ".arready"}, s_axil_arready, 0);
        check({tag, ".bvalid"}, s_axil_bvalid, 0);
        check({tag, ".rvalid"}, s_axil_rvalid, 0);
        check({tag, ".wen"}, o_reg_wen, 0);
        check({tag, ".ren"}, o_reg_ren, 0);
        check({tag, ".waddr"}, o_reg_waddr, 0);
        check({tag, ".wdata"}, o_reg_wdata, 0);
        check({tag, ".raddr"}, o_reg_raddr, 0);
        check({tag, ".rdata"}, s_axil_rdata, 0);
        check({tag, ".bresp"}, s_axil_bresp, 0);
        check({tag, ".rresp"}, s_axil_rresp, 0);
    endtask

    // Entered in the handshake cycle T (just after the grant check); returns on the negedge after the B handshake.
    task automatic serve_write(input logic [15:0] wa, input logic [63:0] wd, input int bdly);
        bit err = addr_err(wa);
        check("wr.T.wen", o_reg_wen, 0);
        check("wr.T.bvalid", s_axil_bvalid, 0);
        @(negedge clk);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        #1;
        check_busy("wr.T1", !err, 0);
        check("wr.T1.bvalid", s_axil_bvalid, 0);
        if (!err) begin
            check("wr.T1.waddr", o_reg_waddr, wa);
            check("wr.T1.wdata", o_reg_wdata, wd);
            exp_mem[wa] = wd;
        end
        for (int i = 0; i <= bdly; i++) begin
            @(negedge clk);
            #1;
            check("wr.resp.bvalid", s_axil_bvalid, 1);
            check("wr.resp.bresp", s_axil_bresp, err ? 2'b10 : 2'b00);
            check_busy("wr.resp", 0, 0);
            if (i == bdly) s_axil_bready = 1'b1;
        end
        @(negedge clk);
        s_axil_bready = 1'b0;
    endtask

    task automatic serve_read(input logic [15:0] ra, input int rdly);
        bit          err = addr_err(ra);
        logic [63:0] exp = err ? 64'd0 : exp_rd(ra);
        check("rd.T.ren", o_reg_ren, 0);
        check("rd.T.rvalid", s_axil_rvalid, 0);
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        #1;
        check_busy("rd.T1", 0, !err);
        check("rd.T1.rvalid", s_axil_rvalid, 0);
        if (!err) begin
            check("rd.T1.raddr", o_reg_raddr, ra);
            for (int i = 0; i < RD_LATENCY; i++) begin
                @(negedge clk);
                #1;
                check("rd.wait.rvalid", s_axil_rvalid, 0);
                check_busy("rd.wait", 0, 0);
            end
        end
        for (int i = 0; i <= rdly; i++) begin
            @(negedge clk);
            #1;
            check("rd.resp.rvalid", s_axil_rvalid, 1);
            check("rd.resp.rdata", s_axil_rdata, exp);
            check("rd.resp.rresp", s_axil_rresp, err ? 2'b10 : 2'b00);
            check_busy("rd.resp", 0, 0);
            if (i == rdly) s_axil_rready = 1'b1;
        end
        @(negedge clk);
        s_axil_rready = 1'b0;
    endtask

    // Called at a negedge with the bridge idle; presents a write, a read or both in the same cycle.
    task automatic run_txn(input bit wr, input bit rd, input logic [15:0] wa, input logic [63:0] wd,
                           input logic [15:0] ra, input int bdly, input int rdly);
        bit wr_p = wr;
        bit rd_p = rd;
        bit go_wr;
        s_axil_awaddr  = {16'($urandom), wa};
        s_axil_wdata   = wd;
        s_axil_wstrb   = 8'($urandom);
        s_axil_araddr  = {16'($urandom), ra};
        s_axil_awvalid = wr;
        s_axil_wvalid  = wr;
        s_axil_arvalid = rd;
        while (wr_p || rd_p) begin
            #1;
            go_wr = wr_p && (!rd_p || prio_wr);
            check("grant.awready", s_axil_awready, go_wr);
            check("grant.wready", s_axil_wready, go_wr);
            check("grant.arready", s_axil_arready, !go_wr);
            check("grant.bvalid", s_axil_bvalid, 0);
            check("grant.rvalid", s_axil_rvalid, 0);
            prio_wr = !go_wr;
            if (go_wr) begin
                wr_p = 1'b0;
                serve_write(wa, wd, bdly);
            end else begin
                rd_p = 1'b0;
                serve_read(ra, rdly);
            end
        end
    endtask

    task automatic reset_in_rd_wait(input logic [15:0] ra);
        s_axil_araddr  = {16'h0, ra};
        s_axil_arvalid = 1'b1;
        #1;
        check("rst.grant.arready", s_axil_arready, 1);
        @(negedge clk);
        s_axil_arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst.wait.rvalid", s_axil_rvalid, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst.mid");
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        prio_wr = 1'b1;
        for (int i = 0; i < RD_LATENCY + 6; i++) begin
            @(negedge clk);
            #1;
            check("rst.after.rvalid", s_axil_rvalid, 0);
            check("rst.after.ren", o_reg_ren, 0);
            check("rst.after.wen", o_reg_wen, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        blk_mem[16'h0038] = 64'h9000_0000_0000_03FF;
        exp_mem[16'h0038] = 64'h9000_0000_0000_03FF;
        run_txn(1, 0, 16'h0028, 64'h0000_0000_0001_0000, 16'h0, 0, 0);
        run_txn(0, 1, 16'h0, 64'h0, 16'h0038, 0, 0);

        // Two simultaneous requests, twice: write then read each time.
        run_txn(1, 1, 16'h0040, {$urandom, $urandom}, 16'h0028, 1, 0);
        run_txn(1, 1, 16'h0048, {$urandom, $urandom}, 16'h0040, 0, 2);

        // After a lone write the read wins the tie; its response is stalled for 20 cycles.
        run_txn(1, 0, 16'h0050, {$urandom, $urandom}, 16'h0, 0, 0);
        run_txn(1, 1, 16'h0058, {$urandom, $urandom}, 16'h0050, 0, 20);

`ifdef REG_BRIDGE_ADDR_CHECK_EN
        run_txn(1, 0, 16'h0104, {$urandom, $urandom}, 16'h0, 0, 0);
        run_txn(0, 1, 16'h0, 64'h0, 16'h0013, 0, 0);
        run_txn(0, 1, 16'h0, 64'h0, 16'h0100, 0, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 2);
            run_txn(kind != 1, kind != 0, rand_addr(), {$urandom, $urandom}, rand_addr(),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        reset_in_rd_wait(16'h0038);
        run_txn(1, 0, 16'h0060, 64'hDEAD_BEEF_0123_4567, 16'h0, 0, 0);
        run_txn(0, 1, 16'h0, 64'h0, 16'h0060, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
